booth_ctrl: RTL and testbench
=============================

Name: booth_ctrl

Overview:
- Control sequencer (initiator) for the radix-2 Booth multiplier datapath.
- Generates one-cycle control strobes c0..c6 consumed by the A, Q and M registers, the adder/subtractor and the output bus drivers.
- Reads Booth pair {q0, q_m1} back from the Q register; reports busy/done to the system.
- Sits between top-level start/done handshake and the datapath registers.

Parameters:
- N, 8, operand width = number of Booth iterations (N >= 2).
- CNT_W, 3, iteration counter width, $clog2(N).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request new multiplication; sampled only in IDLE
- q0  input  1  Q[0] from Q register
- q_m1  input  1  Q[-1] extension bit from Q register
- c0  output  1  clear A, Q[-1], load M from inbus
- c1  output  1  load Q from inbus
- c2  output  1  write adder result into A
- c3  output  1  adder op select: 1 = A - M, 0 = A + M (valid only with c2)
- c4  output  1  arithmetic shift right A:Q:Q[-1]
- c5  output  1  drive A onto obus
- c6  output  1  drive Q onto obus
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, operation finished

Behaviour:
- Reset: synchronous, active-high; one clock with rst=1 forces state IDLE, cnt=0; from that edge c0..c6=0, busy=0, done=0. rst has priority over all other inputs; reset mid-operation aborts with no further strobes.
- States: IDLE, INIT, LOADQ, ADDSUB, SHIFT, OUT_A, OUT_Q, DONE. Encoding free.
- IDLE: all outputs 0; start=1 at edge -> INIT.
- INIT: c0=1; cnt<=0; -> LOADQ.
- LOADQ: c1=1; -> ADDSUB.
- ADDSUB (Mealy on q0,q_m1 in the same cycle): 10 -> c2=1,c3=1; 01 -> c2=1,c3=0; 00/11 -> c2=0,c3=0; -> SHIFT.
- SHIFT: c4=1; if cnt==N-1 -> OUT_A, cnt<=0; else cnt<=cnt+1, -> ADDSUB.
- OUT_A: c5=1 -> OUT_Q. OUT_Q: c6=1 -> DONE. DONE: done=1 -> IDLE.
- Strobes other than c2/c3 are pure decode of the state register (Moore). At most one of c0,c1,c2,c4,c5,c6 is high in any cycle; c5 and c6 never overlap, so the tri-state obus is never contended.
- Latency: start sampled at edge k -> INIT in cycle k+1; done high in cycle k+2N+5 (N=8: cycle 21). busy high in cycles k+1..k+2N+5.
- start while busy: ignored, no effect on sequence or timing.
- start held high: after DONE, IDLE samples start again -> next INIT one cycle after done (one IDLE cycle between operations).
- q0/q_m1 are ignored in every state except ADDSUB.

Optional Feature:
- Macro BOOTH_SKIP_NOP_EN.
- Defined: in ADDSUB with pair 00/11, assert c4 instead of entering SHIFT. Apply the SHIFT counter/exit rules in that cycle, going to ADDSUB or OUT_A. A no-op iteration takes 1 cycle; an add/sub iteration still takes 2. Latency becomes 2N+5 minus the number of no-op iterations.
- Undefined: fixed 2-cycle iterations as above; c4 never asserted in ADDSUB.

Test Plan:
- rst=1 for 2 cycles mid-run (cycle 7 after start) -> next cycle all c*=0, busy=0, done=0. A subsequent start completes in exactly 21 cycles.
- N=8, {q0,q_m1}=00 held, start pulse -> c0 in cycle 1, c1 in cycle 2, c4 in cycles 4,6,...,18, no c2/c3, c5 cycle 19, c6 cycle 20, done cycle 21, busy cycles 1-21.
- Pair driven 10, 01, 11, 00 in successive ADDSUB cycles -> (c2,c3) = (1,1), (1,0), (0,0), (0,0) respectively. c2/c3 never high outside ADDSUB.
- start pulsed in cycles 5 and 12 while busy -> sequence identical to the previous case, single done at cycle 21.
- start held high continuously -> done at cycle 21, IDLE cycle 22, c0 at cycle 23, second done at cycle 43.
- BOOTH_SKIP_NOP_EN defined, pair 00 held -> c4 in cycles 3..10, c5 cycle 11, c6 cycle 12, done cycle 13. Pair 10 held -> timing identical to the non-macro build (done cycle 21).

Source files
------------

// File: rtl/booth_ctrl.sv
// Control sequencer for the radix-2 Booth multiplier datapath: one-cycle strobes c0..c6, busy/done.
// Optional BOOTH_SKIP_NOP_EN: no-op Booth pairs (00/11) shift directly in ADDSUB, saving one cycle each.
module booth_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_m1,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    LOADQ,
    ADDSUB,
    SHIFT,
    OUT_A,
    OUT_Q,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               last_iter;
  logic               pair_op;

  assign last_iter = (cnt == CNT_W'(N - 1));
  assign pair_op   = q0 ^ q_m1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    c0        = 1'b0;
    c1        = 1'b0;
    c2        = 1'b0;
    c3        = 1'b0;
    c4        = 1'b0;
    c5        = 1'b0;
    c6        = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        c0        = 1'b1;
        cnt_nxt   = '0;
        state_nxt = LOADQ;
      end
      LOADQ: begin
        c1        = 1'b1;
        state_nxt = ADDSUB;
      end
      ADDSUB: begin
        // 10 -> A - M, 01 -> A + M, 00/11 -> no arithmetic
        c2 = pair_op;
        c3 = q0 & ~q_m1;
`ifdef BOOTH_SKIP_NOP_EN
        if (!pair_op) begin
          // no-op iteration folds the shift into this cycle
          c4 = 1'b1;
          if (last_iter) begin
            cnt_nxt   = '0;
            state_nxt = OUT_A;
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = ADDSUB;
          end
        end else begin
          state_nxt = SHIFT;
        end
`else
        state_nxt = SHIFT;
`endif
      end
      SHIFT: begin
        c4 = 1'b1;
        if (last_iter) begin
          cnt_nxt   = '0;
          state_nxt = OUT_A;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = ADDSUB;
        end
      end
      OUT_A: begin
        c5        = 1'b1;
        state_nxt = OUT_Q;
      end
      OUT_Q: begin
        c6        = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl: per-cycle strobe schedule checks plus hand-computed done cycles.
module tb_booth_ctrl;
  localparam int N    = 8;
  localparam int MAXC = 64;
`ifdef BOOTH_SKIP_NOP_EN
  localparam bit SKIP        = 1'b1;
  localparam int DONE_HOLD00 = 13;
  localparam int DONE_PAIRS  = 15;
  localparam int DONE_HELD2  = 27;
`else
  localparam bit SKIP        = 1'b0;
  localparam int DONE_HOLD00 = 21;
  localparam int DONE_PAIRS  = 21;
  localparam int DONE_HELD2  = 43;
`endif

  logic clk = 1'b0;
  logic rst, start, q0, q_m1;
  logic c0, c1, c2, c3, c4, c5, c6, busy, done;
  logic [8:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  // expected vector bit order: {c0,c1,c2,c3,c4,c5,c6,busy,done}
  logic [8:0] exp_v   [MAXC];
  logic       start_at[MAXC];
  logic       rst_at  [MAXC];
  logic [1:0] pair_at [MAXC];
  logic [1:0] it_pair [N];

  booth_ctrl #(.N(N), .CNT_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .q0   (q0),
    .q_m1 (q_m1),
    .c0   (c0),
    .c1   (c1),
    .c2   (c2),
    .c3   (c3),
    .c4   (c4),
    .c5   (c5),
    .c6   (c6),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;
  assign obs = {c0, c1, c2, c3, c4, c5, c6, busy, done};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic clear_tables(input logic [1:0] idle_pair);
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i]    = '0;
      start_at[i] = 1'b0;
      rst_at[i]   = 1'b0;
      pair_at[i]  = idle_pair;
    end
  endtask

  // Lays out one operation whose INIT cycle is t0, driving it_pair[] in its ADDSUB cycles.
  task automatic build_op(input int t0, output int t_done);
    int t;
    logic [1:0] p;
    t = t0;
    exp_v[t][8] = 1'b1;
    t++;
    exp_v[t][7] = 1'b1;
    t++;
    for (int it = 0; it < N; it++) begin
      p = it_pair[it];
      pair_at[t] = p;
      if (p == 2'b10) begin
        exp_v[t][6] = 1'b1;
        exp_v[t][5] = 1'b1;
      end else if (p == 2'b01) begin
        exp_v[t][6] = 1'b1;
      end
      if (SKIP && (p == 2'b00 || p == 2'b11)) begin
        exp_v[t][4] = 1'b1;
        t++;
      end else begin
        t++;
        exp_v[t][4] = 1'b1;
        t++;
      end
    end
    exp_v[t][3]   = 1'b1;
    exp_v[t+1][2] = 1'b1;
    exp_v[t+2][0] = 1'b1;
    for (int b = t0; b <= t + 2; b++) exp_v[b][1] = 1'b1;
    t_done = t + 2;
  endtask

  task automatic run_seq(input string name, input int len,
                         output int first_done, output int last_done, output int n_done);
    first_done = -1;
    last_done  = -1;
    n_done     = 0;
    @(negedge clk);
    start = start_at[0];
    rst   = rst_at[0];
    {q0, q_m1} = pair_at[0];
    for (int t = 1; t <= len; t++) begin
      @(posedge clk);
      #1;
      start = start_at[t];
      rst   = rst_at[t];
      {q0, q_m1} = pair_at[t];
      @(negedge clk);
      check_val($sformatf("%s t=%0d", name, t), 32'(obs), 32'(exp_v[t]));
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = t;
        last_done = t;
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int fd, ld, nd, td1, td2;
    rst = 1'b1;
    start = 1'b0;
    q0 = 1'b0;
    q_m1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset", 32'(obs), 32'h0);
    rst = 1'b0;

    // pair 00 held everywhere
    clear_tables(2'b00);
    for (int i = 0; i < N; i++) it_pair[i] = 2'b00;
    start_at[0] = 1'b1;
    build_op(1, td1);
    run_seq("hold00", 23, fd, ld, nd);
    check_val("hold00_done_cyc", 32'(fd), 32'(DONE_HOLD00));
    check_val("hold00_done_cnt", 32'(nd), 32'd1);

    // successive pairs 10,01,11,00; 01 driven outside ADDSUB must be ignored
    clear_tables(2'b01);
    it_pair[0] = 2'b10;
    it_pair[1] = 2'b01;
    it_pair[2] = 2'b11;
    for (int i = 3; i < N; i++) it_pair[i] = 2'b00;
    start_at[0] = 1'b1;
    build_op(1, td1);
    run_seq("pairs", 23, fd, ld, nd);
    check_val("pairs_done_cyc", 32'(fd), 32'(DONE_PAIRS));

    // start pulses while busy change nothing
    clear_tables(2'b00);
    for (int i = 0; i < N; i++) it_pair[i] = 2'b00;
    start_at[0]  = 1'b1;
    start_at[5]  = 1'b1;
    start_at[12] = 1'b1;
    build_op(1, td1);
    run_seq("busy_start", 23, fd, ld, nd);
    check_val("busy_start_done_cyc", 32'(fd), 32'(DONE_HOLD00));
    check_val("busy_start_done_cnt", 32'(nd), 32'd1);

    // start held high: back-to-back operations with one IDLE cycle between
    clear_tables(2'b00);
    for (int i = 0; i < MAXC; i++) start_at[i] = 1'b1;
    build_op(1, td1);
    build_op(td1 + 2, td2);
    run_seq("held", td2, fd, ld, nd);
    check_val("held_done1_cyc", 32'(fd), 32'(DONE_HOLD00));
    check_val("held_done2_cyc", 32'(ld), 32'(DONE_HELD2));
    check_val("held_done_cnt", 32'(nd), 32'd2);

    // reset for two cycles starting in cycle 7 aborts the operation
    clear_tables(2'b00);
    for (int i = 0; i < N; i++) it_pair[i] = 2'b00;
    start_at[0] = 1'b1;
    build_op(1, td1);
    rst_at[7] = 1'b1;
    rst_at[8] = 1'b1;
    for (int i = 8; i < MAXC; i++) exp_v[i] = '0;
    run_seq("midrst", 12, fd, ld, nd);
    check_val("midrst_done_cnt", 32'(nd), 32'd0);

    // fresh operation after the abort; add/sub pairs give the full 21 cycles in both builds
    clear_tables(2'b10);
    for (int i = 0; i < N; i++) it_pair[i] = 2'b10;
    start_at[0] = 1'b1;
    build_op(1, td1);
    run_seq("after_rst", 22, fd, ld, nd);
    check_val("after_rst_done_cyc", 32'(fd), 32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
